// File: rtl/kme_if.sv
// -----------------------------------------------------------------------------
// kme_if -- bus bundle for the KME front end.
//   Inbound key-descriptor AXI-Stream (kme_ib_*), CCEIP0 outbound AXI-Stream
//   (kme_cceip0_ob_*) and the APB slave port (apb_*).
//   modport slave  : the KME side (receives ib, drives ob, answers APB)
//   modport master : the environment side (drives ib, receives ob, issues APB)
// -----------------------------------------------------------------------------
interface kme_if #(
  parameter int AW = 16
);
  // Inbound stream
  logic          kme_ib_tvalid;
  logic          kme_ib_tready;
  logic [63:0]   kme_ib_tdata;
  logic [7:0]    kme_ib_tstrb;
  logic [7:0]    kme_ib_tuser;
  logic          kme_ib_tid;
  logic          kme_ib_tlast;
  // Outbound stream
  logic          kme_cceip0_ob_tvalid;
  logic          kme_cceip0_ob_tready;
  logic [63:0]   kme_cceip0_ob_tdata;
  logic [7:0]    kme_cceip0_ob_tstrb;
  logic [7:0]    kme_cceip0_ob_tuser;
  logic          kme_cceip0_ob_tid;
  logic          kme_cceip0_ob_tlast;
  // APB
  logic [AW-1:0] apb_paddr;
  logic          apb_psel;
  logic          apb_penable;
  logic          apb_pwrite;
  logic [31:0]   apb_pwdata;
  logic [31:0]   apb_prdata;
  logic          apb_pready;
  logic          apb_pslverr;

  modport slave (
    input  kme_ib_tvalid, kme_ib_tdata, kme_ib_tstrb, kme_ib_tuser, kme_ib_tid, kme_ib_tlast,
    output kme_ib_tready,
    output kme_cceip0_ob_tvalid, kme_cceip0_ob_tdata, kme_cceip0_ob_tstrb,
           kme_cceip0_ob_tuser, kme_cceip0_ob_tid, kme_cceip0_ob_tlast,
    input  kme_cceip0_ob_tready,
    input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
    output apb_prdata, apb_pready, apb_pslverr
  );

  modport master (
    output kme_ib_tvalid, kme_ib_tdata, kme_ib_tstrb, kme_ib_tuser, kme_ib_tid, kme_ib_tlast,
    input  kme_ib_tready,
    input  kme_cceip0_ob_tvalid, kme_cceip0_ob_tdata, kme_cceip0_ob_tstrb,
           kme_cceip0_ob_tuser, kme_cceip0_ob_tid, kme_cceip0_ob_tlast,
    output kme_cceip0_ob_tready,
    output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
    input  apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/kme.sv
// -----------------------------------------------------------------------------
// kme -- key-management-engine front end.
//   Forwards TLV words from the inbound stream to the CCEIP0 outbound stream
//   through a small FIFO, dropping whole TLVs whose type is filtered, and
//   exposes control/status/counters/interrupts over a zero-wait APB slave.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   bus (kme_if.slave)         inbound stream, outbound stream, APB
//   scan_*, ovstb, lvm, mlvm   DFT/memory pins, functionally unused
//   disable_debug_cmd          force-drop TLV type 0x0B
//   disable_unencrypted_keys   force-drop TLV type 0x0C (raises INT_STATUS[0])
//   kme_interrupt              |(INT_STATUS & INT_MASK)
//   kme_idle                   FIFO empty, no TLV open, no inbound valid
// -----------------------------------------------------------------------------
module kme #(
  parameter int AW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  kme_if.slave bus,
  input  logic scan_en,
  input  logic scan_mode,
  input  logic scan_rst_n,
  input  logic ovstb,
  input  logic lvm,
  input  logic mlvm,
  input  logic disable_debug_cmd,
  input  logic disable_unencrypted_keys,
  output logic kme_interrupt,
  output logic kme_idle
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [7:0] USER_SOT = 8'h01;
  localparam logic [7:0] USER_EOT = 8'h02;

  localparam logic [AW-1:0] ADDR_REVISION   = AW'('h00);
  localparam logic [AW-1:0] ADDR_CONTROL    = AW'('h04);
  localparam logic [AW-1:0] ADDR_DROP_MASK  = AW'('h08);
  localparam logic [AW-1:0] ADDR_IN_TLV     = AW'('h0C);
  localparam logic [AW-1:0] ADDR_OUT_TLV    = AW'('h10);
  localparam logic [AW-1:0] ADDR_DROP_CNT   = AW'('h14);
  localparam logic [AW-1:0] ADDR_INT_STATUS = AW'('h18);
  localparam logic [AW-1:0] ADDR_INT_MASK   = AW'('h1C);
  localparam logic [AW-1:0] ADDR_SCRATCH    = AW'('h20);

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  user;
    logic        id;
  } fifo_entry_t;

  fifo_entry_t r_mem [FIFO_DEPTH];
  fifo_entry_t w_head;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic r_tlv_open, r_drop;
  logic r_enable;
  logic [31:0] r_drop_mask, r_in_cnt, r_out_cnt, r_drop_cnt, r_scratch;
  logic [1:0]  r_int_status, r_int_mask;

  logic w_full, w_empty, w_accept, w_is_sot, w_is_eot;
  logic w_sot_drop, w_word_drop, w_push, w_pop;
  logic [7:0] w_type;
  logic w_apb_acc, w_apb_wr, w_hit;
  logic [31:0] w_rdata;
  logic [1:0]  w_int_set, w_int_clr;
  logic w_unused;

  // Pins with no function in this block; folded here so they are visibly consumed.
  assign w_unused = ^{scan_en, scan_mode, scan_rst_n, ovstb, lvm, mlvm, bus.kme_ib_tlast};

  // ---------------- datapath decode ----------------
  // ib_tready comes from the registered count only, so a pop while full frees
  // the slot one cycle later instead of creating a ready->valid comb path.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = bus.kme_ib_tvalid && !w_full;
  assign w_is_sot = (bus.kme_ib_tuser == USER_SOT);
  assign w_is_eot = (bus.kme_ib_tuser == USER_EOT);
  assign w_type   = bus.kme_ib_tdata[7:0];

  assign w_sot_drop = ((w_type < 8'd32) && r_drop_mask[w_type[4:0]])
                   || ((w_type == 8'h0B) && disable_debug_cmd)
                   || ((w_type == 8'h0C) && disable_unencrypted_keys)
                   || !r_enable;

  // A SoT decides for itself; later words follow the flag latched at SoT, and
  // words outside any TLV are always forwarded.
  assign w_word_drop = w_is_sot ? w_sot_drop : (r_tlv_open && r_drop);
  assign w_push      = w_accept && !w_word_drop;
  assign w_pop       = !w_empty && bus.kme_cceip0_ob_tready;
  assign w_head      = r_mem[r_rd_ptr];

  assign bus.kme_ib_tready        = !w_full;
  assign bus.kme_cceip0_ob_tvalid = !w_empty;
  // Fields are gated by empty so stale storage never shows on the bus.
  assign bus.kme_cceip0_ob_tdata  = w_empty ? '0 : w_head.data;
  assign bus.kme_cceip0_ob_tstrb  = w_empty ? '0 : w_head.strb;
  assign bus.kme_cceip0_ob_tuser  = w_empty ? '0 : w_head.user;
  assign bus.kme_cceip0_ob_tid    = w_empty ? 1'b0 : w_head.id;
  assign bus.kme_cceip0_ob_tlast  = !w_empty && (w_head.user == USER_EOT);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; validity is tracked by r_count, so resetting
  // the array would only add reset fan-out and block RAM inference.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.kme_ib_tdata, bus.kme_ib_tstrb, bus.kme_ib_tuser, bus.kme_ib_tid};
  end

  // NOTE: every clocked state update uses <= so all flops sample pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tlv_open <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept) begin
        if (w_is_sot) begin
          r_tlv_open <= 1'b1;
          r_drop     <= w_sot_drop;
        end else if (w_is_eot) begin
          r_tlv_open <= 1'b0;
          r_drop     <= 1'b0;
        end
      end
    end
  end

  // ---------------- APB ----------------
  assign w_apb_acc = bus.apb_psel && bus.apb_penable;
  assign w_apb_wr  = w_apb_acc && bus.apb_pwrite && w_hit;

  // NOTE: both outputs get a default first so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    w_hit   = 1'b1;
    w_rdata = '0;
    case (bus.apb_paddr)
      ADDR_REVISION:   w_rdata = 32'h0001_0000;
      ADDR_CONTROL:    w_rdata = {31'd0, r_enable};
      ADDR_DROP_MASK:  w_rdata = r_drop_mask;
      ADDR_IN_TLV:     w_rdata = r_in_cnt;
      ADDR_OUT_TLV:    w_rdata = r_out_cnt;
      ADDR_DROP_CNT:   w_rdata = r_drop_cnt;
      ADDR_INT_STATUS: w_rdata = {30'd0, r_int_status};
      ADDR_INT_MASK:   w_rdata = {30'd0, r_int_mask};
      ADDR_SCRATCH:    w_rdata = r_scratch;
      default:         w_hit   = 1'b0;
    endcase
  end

  assign bus.apb_prdata  = w_apb_acc ? w_rdata : '0;
  assign bus.apb_pready  = w_apb_acc;
  assign bus.apb_pslverr = w_apb_acc && !w_hit;

  assign w_int_set[1] = w_accept && w_is_sot && r_tlv_open;
  assign w_int_set[0] = w_accept && w_is_sot && (w_type == 8'h0C) && disable_unencrypted_keys;
  assign w_int_clr    = (w_apb_wr && (bus.apb_paddr == ADDR_INT_STATUS)) ? bus.apb_pwdata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable     <= 1'b1;
      r_drop_mask  <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_int_status <= '0;
      r_int_mask   <= '0;
      r_scratch    <= '0;
    end else begin
      if (w_apb_wr) begin
        case (bus.apb_paddr)
          ADDR_CONTROL:   r_enable    <= bus.apb_pwdata[0];
          ADDR_DROP_MASK: r_drop_mask <= bus.apb_pwdata;
          ADDR_INT_MASK:  r_int_mask  <= bus.apb_pwdata[1:0];
          ADDR_SCRATCH:   r_scratch   <= bus.apb_pwdata;
          default: ;
        endcase
      end
      if (w_accept && w_is_sot)               r_in_cnt   <= r_in_cnt + 1'b1;
      if (w_accept && w_is_sot && w_sot_drop) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_pop && (w_head.user == USER_EOT)) r_out_cnt  <= r_out_cnt + 1'b1;
      // Set wins over a same-cycle W1C.
      r_int_status <= (r_int_status & ~w_int_clr) | w_int_set;
    end
  end

  assign kme_interrupt = |(r_int_status & r_int_mask);
  assign kme_idle      = w_empty && !r_tlv_open && !bus.kme_ib_tvalid;

endmodule

// File: tb/tb_kme.sv
// -----------------------------------------------------------------------------
// tb_kme -- self-checking bench for kme. A TLV-level reference model tracks
// expected outbound words, counters and interrupt bits from accepted words.
// -----------------------------------------------------------------------------
module tb_kme;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kme_if #(.AW(16)) ifc ();
  logic dis_dbg = 1'b0, dis_unenc = 1'b0;
  logic scan_en = 1'b0, scan_mode = 1'b0, scan_rst_n = 1'b1, ovstb = 1'b0, lvm = 1'b0, mlvm = 1'b0;
  logic kme_interrupt, kme_idle;

  kme #(.AW(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .scan_en(scan_en), .scan_mode(scan_mode), .scan_rst_n(scan_rst_n),
    .ovstb(ovstb), .lvm(lvm), .mlvm(mlvm),
    .disable_debug_cmd(dis_dbg), .disable_unencrypted_keys(dis_unenc),
    .kme_interrupt(kme_interrupt), .kme_idle(kme_idle)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic [7:0]  u;
    logic        id;
  } word_t;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  bit rnd_stop;

  // Reference model state
  word_t exp_q[$];
  bit m_open, m_drop, m_en;
  logic [31:0] m_mask, m_in, m_out, m_dropcnt;
  logic [1:0] m_int, m_imask;

  function automatic void mreset();
    exp_q.delete();
    m_open = 0; m_drop = 0; m_en = 1;
    m_mask = 0; m_in = 0; m_out = 0; m_dropcnt = 0; m_int = 0; m_imask = 0;
  endfunction

  function automatic void model_accept(input word_t w);
    logic [7:0] t;
    bit dr;
    t = w.d[7:0];
    acc_cnt++;
    if (w.u == 8'h01) begin
      if (m_open) m_int[1] = 1'b1;
      dr = ((t < 8'd32) && m_mask[t[4:0]]) || (t == 8'h0B && dis_dbg)
        || (t == 8'h0C && dis_unenc) || !m_en;
      m_in++;
      if (dr) m_dropcnt++;
      if (t == 8'h0C && dis_unenc) m_int[0] = 1'b1;
      m_open = 1; m_drop = dr;
      if (!dr) exp_q.push_back(w);
    end else begin
      if (!(m_open && m_drop)) exp_q.push_back(w);
      if (w.u == 8'h02) begin m_open = 0; m_drop = 0; end
    end
  endfunction

  // Monitor: sampled on the falling edge, predicts what the next rising edge does.
  always @(negedge clk) begin
    word_t g, e;
    if (rst_n) begin
      if (ifc.kme_cceip0_ob_tvalid && ifc.kme_cceip0_ob_tready) begin
        g = {ifc.kme_cceip0_ob_tdata, ifc.kme_cceip0_ob_tstrb, ifc.kme_cceip0_ob_tuser, ifc.kme_cceip0_ob_tid};
        pop_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ob_unexpected got d=%h u=%h required no word", g.d, g.u);
        end else begin
          e = exp_q.pop_front();
          if (g !== e || ifc.kme_cceip0_ob_tlast !== (e.u == 8'h02)) begin
            bad++;
            $display("FAIL ob_word got d=%h s=%h u=%h id=%b last=%b required d=%h s=%h u=%h id=%b last=%b",
                     g.d, g.s, g.u, g.id, ifc.kme_cceip0_ob_tlast, e.d, e.s, e.u, e.id, (e.u == 8'h02));
          end
          if (e.u == 8'h02) m_out++;
        end
      end
      if (ifc.kme_ib_tvalid && ifc.kme_ib_tready)
        model_accept({ifc.kme_ib_tdata, ifc.kme_ib_tstrb, ifc.kme_ib_tuser, ifc.kme_ib_tid});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic word_t mk(input logic [63:0] dd, input logic [7:0] uu);
    word_t w;
    w.d = dd; w.s = 8'hFF; w.u = uu; w.id = 1'b0;
    return w;
  endfunction

  function automatic word_t mk_r(input logic [7:0] t, input logic [7:0] uu);
    word_t w;
    w.d = {$urandom, $urandom}; w.s = 8'($urandom); w.u = uu; w.id = 1'($urandom);
    if (uu == 8'h01) w.d[7:0] = t;
    return w;
  endfunction

  // ---------------- drivers (inputs change 1 time unit after rising edge) ----------------
  task automatic send_burst(input word_t ws[$]);
    int n;
    foreach (ws[i]) begin
      ifc.kme_ib_tvalid = 1'b1;
      {ifc.kme_ib_tdata, ifc.kme_ib_tstrb, ifc.kme_ib_tuser, ifc.kme_ib_tid} = ws[i];
      ifc.kme_ib_tlast = (ws[i].u == 8'h02);
      n = 0;
      @(negedge clk);
      while (!ifc.kme_ib_tready && n < 500) begin n++; @(negedge clk); end
      if (n >= 500) begin
        total++; bad++;
        $display("FAIL ib_accept_timeout got tready=0 required 1");
        ifc.kme_ib_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    ifc.kme_ib_tvalid = 1'b0;
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    ifc.apb_paddr = a; ifc.apb_pwdata = d; ifc.apb_pwrite = 1'b1;
    ifc.apb_psel = 1'b1; ifc.apb_penable = 1'b0;
    @(posedge clk); #1;
    ifc.apb_penable = 1'b1;
    @(posedge clk); #1;
    ifc.apb_psel = 1'b0; ifc.apb_penable = 1'b0; ifc.apb_pwrite = 1'b0;
    case (a)
      16'h04: m_en = d[0];
      16'h08: m_mask = d;
      16'h18: m_int = m_int & ~d[1:0];
      16'h1C: m_imask = d[1:0];
      default: ;
    endcase
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic err);
    ifc.apb_paddr = a; ifc.apb_pwrite = 1'b0; ifc.apb_psel = 1'b1; ifc.apb_penable = 1'b0;
    @(posedge clk); #1;
    ifc.apb_penable = 1'b1;
    @(negedge clk);
    d = ifc.apb_prdata; err = ifc.apb_pslverr;
    total++;
    if (ifc.apb_pready !== 1'b1) begin
      bad++; $display("FAIL apb_pready addr=%h got %b required 1", a, ifc.apb_pready);
    end
    @(posedge clk); #1;
    ifc.apb_psel = 1'b0; ifc.apb_penable = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || ifc.kme_cceip0_ob_tvalid) && n < 300) begin
      @(negedge clk); n++;
    end
    total++;
    if (exp_q.size() != 0 || ifc.kme_cceip0_ob_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d ob_tvalid=%b required 0/0", nm, exp_q.size(), ifc.kme_cceip0_ob_tvalid);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total += 9;
    if (ifc.kme_ib_tready !== 1'b1)        begin bad++; $display("FAIL rst_ib_tready got %b required 1", ifc.kme_ib_tready); end
    if (ifc.kme_cceip0_ob_tvalid !== 1'b0) begin bad++; $display("FAIL rst_ob_tvalid got %b required 0", ifc.kme_cceip0_ob_tvalid); end
    if (ifc.kme_cceip0_ob_tlast !== 1'b0)  begin bad++; $display("FAIL rst_ob_tlast got %b required 0", ifc.kme_cceip0_ob_tlast); end
    if ({ifc.kme_cceip0_ob_tdata, ifc.kme_cceip0_ob_tstrb, ifc.kme_cceip0_ob_tuser, ifc.kme_cceip0_ob_tid} !== '0)
      begin bad++; $display("FAIL rst_ob_fields got d=%h required 0", ifc.kme_cceip0_ob_tdata); end
    if (ifc.apb_prdata !== 32'd0)  begin bad++; $display("FAIL rst_prdata got %h required 0", ifc.apb_prdata); end
    if (ifc.apb_pready !== 1'b0)   begin bad++; $display("FAIL rst_pready got %b required 0", ifc.apb_pready); end
    if (ifc.apb_pslverr !== 1'b0)  begin bad++; $display("FAIL rst_pslverr got %b required 0", ifc.apb_pslverr); end
    if (kme_interrupt !== 1'b0)    begin bad++; $display("FAIL rst_interrupt got %b required 0", kme_interrupt); end
    if (kme_idle !== 1'b1)         begin bad++; $display("FAIL rst_idle got %b required 1", kme_idle); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    word_t ws[$];
    word_t sot;
    logic [31:0] d; logic e;
    ifc.kme_cceip0_ob_tready = 1'b1;
    sot = mk(64'h0123_4567_89AB_0015, 8'h01);
    ws = '{sot};
    send_burst(ws);
    @(negedge clk);
    total++;
    if (ifc.kme_cceip0_ob_tvalid !== 1'b1 || ifc.kme_cceip0_ob_tdata !== sot.d) begin
      bad++; $display("FAIL pt_latency got valid=%b d=%h required 1 %h", ifc.kme_cceip0_ob_tvalid, ifc.kme_cceip0_ob_tdata, sot.d);
    end
    @(posedge clk); #1;
    ws = '{mk(64'h1111_2222_3333_4444, 8'h03), mk(64'h5555_6666_7777_8888, 8'h02)};
    send_burst(ws);
    wait_drain("pt");
    apb_read(16'h0C, d, e);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL pt_in_cnt got %0d required 1", d); end
    apb_read(16'h10, d, e);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL pt_out_cnt got %0d required 1", d); end
    total++; if (kme_idle !== 1'b1) begin bad++; $display("FAIL pt_idle got %b required 1", kme_idle); end
  endtask

  task automatic test_drop_mask();
    word_t ws[$];
    logic [31:0] d; logic e;
    apb_write(16'h08, 32'h0000_0100);
    ws = '{mk(64'hA0A0_0000_0000_0008, 8'h01), mk(64'hA1, 8'h00), mk(64'hA2, 8'h02),
           mk(64'hB0B0_0000_0000_0009, 8'h01), mk(64'hB1, 8'h00), mk(64'hB2, 8'h02)};
    send_burst(ws);
    wait_drain("mask");
    apb_read(16'h14, d, e);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL mask_drop_cnt got %0d required 1", d); end
    apb_write(16'h08, 32'h0);
    // enable is latched at SoT: a disabled SoT drops the whole TLV even if re-enabled mid-TLV
    apb_write(16'h04, 32'h0);
    ws = '{mk(64'hC0C0_0000_0000_0015, 8'h01)}; send_burst(ws);
    apb_write(16'h04, 32'h1);
    ws = '{mk(64'hC1, 8'h03), mk(64'hC2, 8'h02)}; send_burst(ws);
    ws = '{mk(64'hD0D0_0000_0000_0015, 8'h01)}; send_burst(ws);
    apb_write(16'h04, 32'h0);
    ws = '{mk(64'hD1, 8'h03), mk(64'hD2, 8'h02)}; send_burst(ws);
    apb_write(16'h04, 32'h1);
    wait_drain("enable");
    apb_read(16'h14, d, e);
    total++; if (d !== m_dropcnt) begin bad++; $display("FAIL en_drop_cnt got %0d required %0d", d, m_dropcnt); end
  endtask

  task automatic test_unencrypted();
    word_t ws[$];
    dis_unenc = 1'b1;
    apb_write(16'h1C, 32'h1);
    ws = '{mk(64'hE0E0_0000_0000_000C, 8'h01), mk(64'hE1, 8'h03), mk(64'hE2, 8'h02)};
    send_burst(ws);
    wait_drain("unenc");
    total++; if (kme_interrupt !== 1'b1) begin bad++; $display("FAIL unenc_irq got %b required 1", kme_interrupt); end
    apb_write(16'h18, 32'h1);
    @(negedge clk);
    total++; if (kme_interrupt !== 1'b0) begin bad++; $display("FAIL unenc_irq_clr got %b required 0", kme_interrupt); end
    @(posedge clk); #1;
    dis_unenc = 1'b0;
    dis_dbg = 1'b1;
    ws = '{mk(64'hF0F0_0000_0000_000B, 8'h01), mk(64'hF1, 8'h02), mk(64'hF2F2_0000_0000_000C, 8'h01), mk(64'hF3, 8'h02)};
    send_burst(ws);
    wait_drain("dbg");
    dis_dbg = 1'b0;
    apb_write(16'h1C, 32'h0);
  endtask

  task automatic test_back_pressure();
    word_t ws[$];
    word_t h0, h1;
    int a0, p0;
    ifc.kme_cceip0_ob_tready = 1'b0;
    ws = '{mk(64'h1000_0000_0000_0021, 8'h01), mk(64'h1001, 8'h00), mk(64'h1002, 8'h03),
           mk(64'h1003, 8'h04), mk(64'h1004, 8'h00), mk(64'h1005, 8'h02)};
    a0 = acc_cnt; p0 = pop_cnt;
    fork
      send_burst(ws);
      begin
        repeat (12) @(negedge clk);
        total += 2;
        if (ifc.kme_ib_tready !== 1'b0) begin bad++; $display("FAIL bp_tready got %b required 0", ifc.kme_ib_tready); end
        if (acc_cnt - a0 != 4) begin bad++; $display("FAIL bp_accepted got %0d required 4", acc_cnt - a0); end
        h0 = {ifc.kme_cceip0_ob_tdata, ifc.kme_cceip0_ob_tstrb, ifc.kme_cceip0_ob_tuser, ifc.kme_cceip0_ob_tid};
        repeat (3) @(negedge clk);
        h1 = {ifc.kme_cceip0_ob_tdata, ifc.kme_cceip0_ob_tstrb, ifc.kme_cceip0_ob_tuser, ifc.kme_cceip0_ob_tid};
        total++;
        if (h1 !== h0 || h0.d !== 64'h1000_0000_0000_0021) begin
          bad++; $display("FAIL bp_hold got d=%h required %h", h1.d, 64'h1000_0000_0000_0021);
        end
        @(posedge clk); #1;
        ifc.kme_cceip0_ob_tready = 1'b1;
        @(negedge clk);
        total++;
        if (ifc.kme_ib_tready !== 1'b0) begin bad++; $display("FAIL bp_full_pop_tready got %b required 0", ifc.kme_ib_tready); end
        @(negedge clk);
        total++;
        if (ifc.kme_ib_tready !== 1'b1) begin bad++; $display("FAIL bp_tready_next got %b required 1", ifc.kme_ib_tready); end
      end
    join
    wait_drain("bp");
    total++;
    if (pop_cnt - p0 != 6) begin bad++; $display("FAIL bp_count got %0d required 6", pop_cnt - p0); end
  endtask

  task automatic test_apb();
    logic [31:0] d; logic e;
    apb_write(16'h20, 32'hDEAD_BEEF);
    apb_read(16'h20, d, e);
    total++; if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin bad++; $display("FAIL apb_scratch got %h err=%b required deadbeef 0", d, e); end
    apb_read(16'h00, d, e);
    total++; if (d !== 32'h0001_0000) begin bad++; $display("FAIL apb_revision got %h required 00010000", d); end
    apb_read(16'h40, d, e);
    total++; if (d !== 32'd0 || e !== 1'b1) begin bad++; $display("FAIL apb_unmapped got %h err=%b required 0 1", d, e); end
    apb_write(16'h40, 32'h1234_5678);
    apb_write(16'h04, 32'hFFFF_FFFF);
    apb_read(16'h04, d, e);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL apb_control got %h required 1", d); end
    apb_read(16'h20, d, e);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL apb_scratch_keep got %h required deadbeef", d); end
  endtask

  task automatic test_random();
    word_t ws[$];
    logic [31:0] d; logic e;
    logic [7:0] mids [4];
    mids[0] = 8'h00; mids[1] = 8'h03; mids[2] = 8'h04; mids[3] = 8'hFF;
    apb_write(16'h08, $urandom);
    apb_write(16'h1C, 32'($urandom_range(0, 3)));
    dis_dbg = 1'($urandom); dis_unenc = 1'($urandom);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] t;
      int nmid;
      case ($urandom_range(0, 7))
        0: t = 8'h08;  1: t = 8'h09;  2: t = 8'h0B;  3: t = 8'h0C;
        4: t = 8'h15;  5: t = 8'h1F;  6: t = 8'h40;  default: t = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) ws.push_back(mk_r(8'h0, mids[$urandom_range(0, 3)]));
      ws.push_back(mk_r(t, 8'h01));
      nmid = $urandom_range(0, 3);
      for (int j = 0; j < nmid; j++) ws.push_back(mk_r(8'h0, mids[$urandom_range(0, 3)]));
      if ($urandom_range(0, 9) != 0) ws.push_back(mk_r(8'h0, 8'h02));
    end
    ws.push_back(mk_r(8'h0, 8'h02));
    rnd_stop = 0;
    fork
      begin send_burst(ws); rnd_stop = 1; end
      while (!rnd_stop) begin
        @(posedge clk); #1;
        ifc.kme_cceip0_ob_tready = ($urandom_range(0, 3) != 0);
      end
    join
    ifc.kme_cceip0_ob_tready = 1'b1;
    wait_drain("rnd");
    apb_read(16'h0C, d, e);
    total++; if (d !== m_in) begin bad++; $display("FAIL rnd_in_cnt got %0d required %0d", d, m_in); end
    apb_read(16'h10, d, e);
    total++; if (d !== m_out) begin bad++; $display("FAIL rnd_out_cnt got %0d required %0d", d, m_out); end
    apb_read(16'h14, d, e);
    total++; if (d !== m_dropcnt) begin bad++; $display("FAIL rnd_drop_cnt got %0d required %0d", d, m_dropcnt); end
    apb_read(16'h18, d, e);
    total++; if (d !== {30'd0, m_int}) begin bad++; $display("FAIL rnd_int_status got %h required %h", d, m_int); end
    total++;
    if (kme_interrupt !== |(m_int & m_imask)) begin
      bad++; $display("FAIL rnd_irq got %b required %b", kme_interrupt, |(m_int & m_imask));
    end
    dis_dbg = 1'b0; dis_unenc = 1'b0;
    apb_write(16'h08, 32'h0);
  endtask

  task automatic test_protocol_reset();
    word_t ws[$];
    logic [31:0] d; logic e;
    logic [15:0] addrs [9];
    logic [31:0] vals [9];
    addrs = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18, 16'h1C, 16'h20};
    vals  = '{32'h0001_0000, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    apb_write(16'h18, 32'h3);
    apb_write(16'h1C, 32'h3);
    ws = '{mk(64'h15, 8'h01), mk(64'h16, 8'h01), mk(64'h17, 8'h02)};
    send_burst(ws);
    wait_drain("proto");
    apb_read(16'h18, d, e);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL proto_int_status got %h required 2", d); end
    ifc.kme_cceip0_ob_tready = 1'b0;
    ws = '{mk(64'h2222_0000_0000_0015, 8'h01), mk(64'h2223, 8'h03)};
    send_burst(ws);
    @(negedge clk);
    rst_n = 1'b0;
    mreset();
    @(negedge clk);
    total += 3;
    if (ifc.kme_cceip0_ob_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_ob_tvalid got %b required 0", ifc.kme_cceip0_ob_tvalid); end
    if (ifc.kme_ib_tready !== 1'b1)        begin bad++; $display("FAIL midrst_ib_tready got %b required 1", ifc.kme_ib_tready); end
    if (kme_idle !== 1'b1 || kme_interrupt !== 1'b0)
      begin bad++; $display("FAIL midrst_idle_irq got %b%b required 10", kme_idle, kme_interrupt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    ifc.kme_cceip0_ob_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      apb_read(addrs[i], d, e);
      total++;
      if (d !== vals[i] || e !== 1'b0) begin
        bad++; $display("FAIL midrst_reg_%h got %h err=%b required %h 0", addrs[i], d, e, vals[i]);
      end
    end
    wait_drain("post_rst");
  endtask

  initial begin
    ifc.kme_ib_tvalid = 1'b0; ifc.kme_ib_tdata = '0; ifc.kme_ib_tstrb = '0;
    ifc.kme_ib_tuser = '0; ifc.kme_ib_tid = 1'b0; ifc.kme_ib_tlast = 1'b0;
    ifc.kme_cceip0_ob_tready = 1'b0;
    ifc.apb_paddr = '0; ifc.apb_psel = 1'b0; ifc.apb_penable = 1'b0;
    ifc.apb_pwrite = 1'b0; ifc.apb_pwdata = '0;
    mreset();
    test_reset();
    test_passthrough();
    test_drop_mask();
    test_unencrypted();
    test_back_pressure();
    test_apb();
    test_random();
    test_protocol_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
